// File: rtl/alisim_pkg.sv
// alisim_pkg: shared nucleotide definitions for the PE-array I/O path.
// Holds the 2-bit code type, ASCII constants, word geometry, the unpacker
// state encoding and the code-to-ASCII mapping. The host-side packer uses
// the same mapping in the reverse direction.
package alisim_pkg;

   localparam int NUCL_PER_WORD = 16;
   localparam int NUCL_WORD_W   = 2 * NUCL_PER_WORD;
   localparam int NUCL_COUNT_W  = 5;

   typedef logic [1:0] nucl_code_t;

   localparam logic [7:0] NUCL_ASCII_A = 8'h41;
   localparam logic [7:0] NUCL_ASCII_C = 8'h43;
   localparam logic [7:0] NUCL_ASCII_G = 8'h47;
   localparam logic [7:0] NUCL_ASCII_T = 8'h54;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_EMIT = 1'b1
   } unpack_state_e;

   function automatic logic [7:0] nucl_to_ascii(input nucl_code_t code);
      logic [7:0] ch;
      case (code)
         2'b00:   ch = NUCL_ASCII_A;
         2'b01:   ch = NUCL_ASCII_C;
         2'b10:   ch = NUCL_ASCII_G;
         default: ch = NUCL_ASCII_T;
      endcase
      return ch;
   endfunction

endpackage

// File: rtl/nucl_stats.sv
// nucl_stats: four saturating counters, one per base, bumped on each
// emitted character. Clear wins over a same-cycle increment.
// Ports:
//   clk, reset       clock and synchronous active-high reset
//   clr_i            synchronous clear of all counters
//   inc_i            a character was handshaken this cycle
//   code_i           2-bit code of that character
//   cnt_a_o..cnt_t_o current counts, saturating at all-ones
module nucl_stats
   import alisim_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr_i,
   input  logic             inc_i,
   input  nucl_code_t       code_i,
   output logic [CNT_W-1:0] cnt_a_o,
   output logic [CNT_W-1:0] cnt_c_o,
   output logic [CNT_W-1:0] cnt_g_o,
   output logic [CNT_W-1:0] cnt_t_o
);

   logic [CNT_W-1:0] cnt_q [4];

   always_ff @(posedge clk) begin
      if (reset || clr_i) begin
         for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
      end else if (inc_i && (cnt_q[code_i] != '1)) begin
         cnt_q[code_i] <= cnt_q[code_i] + 1'b1;
      end
   end

   assign cnt_a_o = cnt_q[0];
   assign cnt_c_o = cnt_q[1];
   assign cnt_g_o = cnt_q[2];
   assign cnt_t_o = cnt_q[3];

endmodule

// File: rtl/nucl_unpacker.sv
// nucl_unpacker: serialises 32-bit packed nucleotide words (16 x 2-bit
// codes, nucleotide 0 in the MSBs) into one ASCII character per cycle.
// Valid/ready on both sides; a word may carry 1..16 characters, and a word
// flagged in_last marks its final character with out_last.
// Ports:
//   clk, reset                   clock, synchronous active-high reset
//   in_valid/in_ready            input word handshake
//   in_word, in_count, in_last   packed codes, character count, end flag
//   out_valid/out_ready          output character handshake
//   out_char, out_last           ASCII character, end-of-sequence marker
//   busy                         a word is held and not fully emitted
//   stats_clr, cnt_a..cnt_t      per-base counters (NUCL_UNPACK_STATS_EN)
// Build option: define NUCL_UNPACK_STATS_EN to add the counter bank.
module nucl_unpacker
   import alisim_pkg::*;
`ifdef NUCL_UNPACK_STATS_EN
#(
   parameter int CNT_W = 16
)
`endif
(
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [NUCL_WORD_W-1:0]  in_word,
   input  logic [NUCL_COUNT_W-1:0] in_count,
   input  logic                    in_last,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [7:0]              out_char,
   output logic                    out_last,
   output logic                    busy
`ifdef NUCL_UNPACK_STATS_EN
   ,
   input  logic                    stats_clr,
   output logic [CNT_W-1:0]        cnt_a,
   output logic [CNT_W-1:0]        cnt_c,
   output logic [CNT_W-1:0]        cnt_g,
   output logic [CNT_W-1:0]        cnt_t
`endif
);

   localparam logic [NUCL_COUNT_W-1:0] FULL_COUNT = NUCL_COUNT_W'(NUCL_PER_WORD);

   unpack_state_e            state_q, state_d;
   logic [NUCL_WORD_W-1:0]   shift_q, shift_d;
   logic [NUCL_COUNT_W-1:0]  remaining_q, remaining_d;
   logic                     last_q, last_d;
   logic                     out_valid_q;
   logic [7:0]               out_char_q;
   logic                     out_last_q;

   logic                     out_hs;
   logic                     in_acc;
   logic [NUCL_COUNT_W-1:0]  count_sat;

   // in_ready looks at out_ready so the next word can load on the same edge
   // that retires the last character, keeping out_valid continuous.
   assign in_ready = !reset &&
                     ((state_q == ST_IDLE) ||
                      ((remaining_q == 5'd1) && out_ready));
   assign out_hs    = (state_q == ST_EMIT) && out_ready;
   assign in_acc    = in_valid && in_ready;
   assign count_sat = (in_count > FULL_COUNT) ? FULL_COUNT : in_count;

   always_comb begin
      state_d     = state_q;
      shift_d     = shift_q;
      remaining_d = remaining_q;
      last_d      = last_q;

      if (out_hs) begin
         shift_d     = shift_q << 2;
         remaining_d = remaining_q - 5'd1;
         if (remaining_q == 5'd1) begin
            state_d = ST_IDLE;
            last_d  = 1'b0;
         end
      end

      // An empty word is simply swallowed; in_ready only rises in EMIT on the
      // final handshake, so the state above has already fallen to IDLE.
      if (in_acc && (count_sat != '0)) begin
         state_d     = ST_EMIT;
         shift_d     = in_word;
         remaining_d = count_sat;
         last_d      = in_last;
      end
   end

   // Outputs are registered from the next-state values so they are stable
   // for the whole cycle and hold automatically while out_ready is low.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         shift_q     <= '0;
         remaining_q <= '0;
         last_q      <= 1'b0;
         out_valid_q <= 1'b0;
         out_char_q  <= 8'h00;
         out_last_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         shift_q     <= shift_d;
         remaining_q <= remaining_d;
         last_q      <= last_d;
         out_valid_q <= (state_d == ST_EMIT);
         out_char_q  <= (state_d == ST_EMIT) ?
                        nucl_to_ascii(shift_d[NUCL_WORD_W-1 -: 2]) : 8'h00;
         out_last_q  <= last_d && (remaining_d == 5'd1);
      end
   end

   assign out_valid = out_valid_q;
   assign out_char  = out_char_q;
   assign out_last  = out_last_q;
   assign busy      = (state_q == ST_EMIT);

`ifdef NUCL_UNPACK_STATS_EN
   nucl_stats #(
      .CNT_W   (CNT_W)
   ) u_stats (
      .clk     (clk),
      .reset   (reset),
      .clr_i   (stats_clr),
      .inc_i   (out_valid_q && out_ready),
      .code_i  (shift_q[NUCL_WORD_W-1 -: 2]),
      .cnt_a_o (cnt_a),
      .cnt_c_o (cnt_c),
      .cnt_g_o (cnt_g),
      .cnt_t_o (cnt_t)
   );
`endif

endmodule

// File: tb/tb_nucl_unpacker.sv
// Directed bench for nucl_unpacker: reset state, full word, back-to-back
// words, partial/empty/oversized counts, backpressure, reset mid-word, and
// (when NUCL_UNPACK_STATS_EN is defined) the saturating counters.
module tb_nucl_unpacker;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_word;
   logic [4:0]  in_count;
   logic        in_last;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  out_char;
   logic        out_last;
   logic        busy;
`ifdef NUCL_UNPACK_STATS_EN
   logic        stats_clr;
   logic [15:0] cnt_a, cnt_c, cnt_g, cnt_t;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   nucl_unpacker dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_word   (in_word),
      .in_count  (in_count),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_char  (out_char),
      .out_last  (out_last),
      .busy      (busy)
`ifdef NUCL_UNPACK_STATS_EN
      ,
      .stats_clr (stats_clr),
      .cnt_a     (cnt_a),
      .cnt_c     (cnt_c),
      .cnt_g     (cnt_g),
      .cnt_t     (cnt_t)
`endif
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   localparam logic [31:0] W_MIX = 32'b01010001011001010010110101010101;

   string s_mix = "CCACCGCCAGTCCCCC";
   string s_tgc = "TGC";
   int    n;
   int    k;
   int    cyc;

   initial begin
      reset     = 1'b1;
      in_valid  = 1'b0;
      in_word   = '0;
      in_count  = '0;
      in_last   = 1'b0;
      out_ready = 1'b0;
`ifdef NUCL_UNPACK_STATS_EN
      stats_clr = 1'b0;
`endif

      // reset state
      tick();
      tick();
      sample();
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_char", 32'(out_char), 32'h00);
      chk("rst_out_last", 32'(out_last), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      tick();
      reset = 1'b0;
      sample();
      chk("rel_in_ready", 32'(in_ready), 32'd1);

      // full word, continuous out_ready
      tick();
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_word   = W_MIX;
      in_count  = 5'd16;
      in_last   = 1'b1;
      sample();
      chk("full_acc_ready", 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 16; i++) begin
         sample();
         chk("full_valid", 32'(out_valid), 32'd1);
         chk("full_char", 32'(out_char), 32'(s_mix[i]));
         chk("full_last", 32'(out_last), 32'(i == 15));
         chk("full_in_ready", 32'(in_ready), 32'(i == 15));
         tick();
      end
      sample();
      chk("full_done_valid", 32'(out_valid), 32'd0);
      chk("full_done_busy", 32'(busy), 32'd0);
`ifdef NUCL_UNPACK_STATS_EN
      chk("stats_a", 32'(cnt_a), 32'd2);
      chk("stats_c", 32'(cnt_c), 32'd11);
      chk("stats_g", 32'(cnt_g), 32'd2);
      chk("stats_t", 32'(cnt_t), 32'd1);
`endif

      // back-to-back words
      tick();
      in_valid = 1'b1;
      in_word  = 32'hFFFF_FFFF;
      in_count = 5'd16;
      in_last  = 1'b0;
      tick();
      in_word = 32'h0000_0000;
      in_last = 1'b1;
      for (int i = 0; i < 16; i++) begin
         sample();
         chk("b2b_t_valid", 32'(out_valid), 32'd1);
         chk("b2b_t_char", 32'(out_char), 32'h54);
         chk("b2b_t_in_ready", 32'(in_ready), 32'(i == 15));
         tick();
      end
      in_valid = 1'b0;
      for (int i = 0; i < 16; i++) begin
         sample();
         chk("b2b_a_valid", 32'(out_valid), 32'd1);
         chk("b2b_a_char", 32'(out_char), 32'h41);
         chk("b2b_a_last", 32'(out_last), 32'(i == 15));
         tick();
      end
      sample();
      chk("b2b_done_valid", 32'(out_valid), 32'd0);

      // partial word, count 3
      tick();
      in_valid = 1'b1;
      in_word  = 32'hE400_0000;
      in_count = 5'd3;
      in_last  = 1'b0;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         sample();
         chk("part_char", 32'(out_char), 32'(s_tgc[i]));
         chk("part_last", 32'(out_last), 32'd0);
         tick();
      end
      sample();
      chk("part_idle_valid", 32'(out_valid), 32'd0);
      chk("part_idle_busy", 32'(busy), 32'd0);

      // empty word with in_last: consumed, nothing emitted
      tick();
      in_valid = 1'b1;
      in_word  = 32'h1234_5678;
      in_count = 5'd0;
      in_last  = 1'b1;
      tick();
      in_valid = 1'b0;
      sample();
      chk("empty_valid", 32'(out_valid), 32'd0);
      chk("empty_last", 32'(out_last), 32'd0);
      chk("empty_busy", 32'(busy), 32'd0);
      chk("empty_in_ready", 32'(in_ready), 32'd1);

      // last-char handshake together with an empty-word accept
      tick();
      in_valid = 1'b1;
      in_word  = 32'hE400_0000;
      in_count = 5'd1;
      in_last  = 1'b1;
      tick();
      in_count = 5'd0;
      sample();
      chk("sim0_in_ready", 32'(in_ready), 32'd1);
      chk("sim0_char", 32'(out_char), 32'h54);
      chk("sim0_last", 32'(out_last), 32'd1);
      tick();
      in_valid = 1'b0;
      sample();
      chk("sim0_idle_valid", 32'(out_valid), 32'd0);
      chk("sim0_idle_busy", 32'(busy), 32'd0);

      // oversized count saturates to 16 characters
      tick();
      in_valid = 1'b1;
      in_word  = 32'h0000_0000;
      in_count = 5'd20;
      in_last  = 1'b0;
      tick();
      in_valid = 1'b0;
      n = 0;
      for (int c = 0; c < 40; c++) begin
         sample();
         if (out_valid) n++;
         tick();
      end
      chk("sat_count_chars", 32'(n), 32'd16);

      // backpressure: out_ready 1,0,0,1 mid-word
      in_valid = 1'b1;
      in_word  = W_MIX;
      in_count = 5'd16;
      in_last  = 1'b0;
      tick();
      in_valid = 1'b0;
      k   = 0;
      cyc = 0;
      while (k < 16 && cyc < 40) begin
         out_ready = !(cyc == 5 || cyc == 6);
         sample();
         chk("bp_valid", 32'(out_valid), 32'd1);
         chk("bp_char", 32'(out_char), 32'(s_mix[k]));
         chk("bp_in_ready", 32'(in_ready), 32'(k == 15 && out_ready));
         tick();
         if (out_ready) k++;
         cyc++;
      end
      chk("bp_cycles", 32'(cyc), 32'd18);
      out_ready = 1'b1;
      sample();
      chk("bp_done_valid", 32'(out_valid), 32'd0);

      // reset after the 5th character
      tick();
      in_valid = 1'b1;
      in_word  = W_MIX;
      in_count = 5'd16;
      in_last  = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         sample();
         chk("mid_char", 32'(out_char), 32'(s_mix[i]));
         tick();
      end
      reset = 1'b1;
      sample();
      chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
      tick();
      reset = 1'b0;
      sample();
      chk("mid_rst_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_char", 32'(out_char), 32'h00);
`ifdef NUCL_UNPACK_STATS_EN
      chk("mid_rst_cnt_a", 32'(cnt_a), 32'd0);
      chk("mid_rst_cnt_c", 32'(cnt_c), 32'd0);
      chk("mid_rst_cnt_g", 32'(cnt_g), 32'd0);
      chk("mid_rst_cnt_t", 32'(cnt_t), 32'd0);
`endif
      tick();
      in_valid = 1'b1;
      in_word  = 32'hE400_0000;
      in_count = 5'd3;
      in_last  = 1'b0;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         sample();
         chk("post_rst_char", 32'(out_char), 32'(s_tgc[i]));
         tick();
      end
      sample();
      chk("post_rst_idle", 32'(out_valid), 32'd0);

`ifdef NUCL_UNPACK_STATS_EN
      // saturation of cnt_a, then clear against a same-cycle increment
      tick();
      stats_clr = 1'b1;
      tick();
      stats_clr = 1'b0;
      in_valid  = 1'b1;
      in_word   = 32'h0000_0000;
      in_count  = 5'd16;
      in_last   = 1'b0;
      for (int c = 0; c < 65600; c++) tick();
      chk("cnt_a_saturated", 32'(cnt_a), 32'h0000_FFFF);
      chk("cnt_c_untouched", 32'(cnt_c), 32'd0);
      stats_clr = 1'b1;
      sample();
      chk("clr_hs_present", 32'(out_valid && out_ready), 32'd1);
      tick();
      stats_clr = 1'b0;
      chk("cnt_a_clr_wins", 32'(cnt_a), 32'd0);
      in_valid = 1'b0;
      for (int c = 0; c < 20; c++) tick();
      sample();
      chk("stats_drain_idle", 32'(busy), 32'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
